// File: rtl/demux2_buf.sv
// 1-to-2 buffered demultiplexer: each accepted word is steered by in_sel into one
// of two independent valid/ready FIFOs, so a stalled sink never blocks the other.
module demux2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    out0_count,
    output logic [CW-1:0]    out1_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]                 fifo_push;
    logic [1:0]                 fifo_pop;
    logic [1:0]                 fifo_valid;
    logic [1:0]                 out_ready;
    logic [1:0][CW-1:0]         count_all;
    logic [1:0][WIDTH-1:0]      head_all;

    assign out_ready = {out1_ready, out0_ready};

    // Ready looks only at the registered occupancy of the selected FIFO, so there
    // is no combinational path from either sink's ready back to the producer.
    assign in_ready = (count_all[in_sel] != FULL);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WIDTH-1:0] mem_reg [DEPTH];
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    rd_ptr_reg;
            logic [CW-1:0]    count_reg;

            assign fifo_push[gi]  = in_valid & in_ready & (in_sel == 1'(gi));
            assign fifo_valid[gi] = (count_reg != '0);
            assign fifo_pop[gi]   = fifo_valid[gi] & out_ready[gi];
            assign count_all[gi]  = count_reg;
            assign head_all[gi]   = mem_reg[rd_ptr_reg];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (fifo_push[gi]) begin
                        mem_reg[wr_ptr_reg] <= in_data;
                        wr_ptr_reg          <= wr_ptr_reg + PW'(1);
                    end
                    if (fifo_pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    // Count disambiguates full from empty; pointers simply wrap.
                    case ({fifo_push[gi], fifo_pop[gi]})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign out0_valid = fifo_valid[0];
    assign out1_valid = fifo_valid[1];
    assign out0_data  = head_all[0];
    assign out1_data  = head_all[1];
    assign out0_count = count_all[0];
    assign out1_count = count_all[1];

endmodule

// File: tb/tb_demux2_buf.sv
// Directed bench for demux2_buf: a pre-edge expectation table plus hand-written
// wrap, simultaneous push/pop and asynchronous-reset sequences.
module tb_demux2_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
    logic [1:0]  out0_count;
    logic [1:0]  out1_count;

    int checks = 0;
    int errors = 0;

    demux2_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
        logic [1:0]  e_c0;
        logic [1:0]  e_c1;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int got;

        // Each row: inputs applied, then the pre-edge outputs expected, then a clock.
        tbl[0]  = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0, 2'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        2'd1, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h12345678, 2'd0, 2'd1};
        tbl[3]  = '{1'b1, 1'b0, 32'hA0000001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0, 2'd0};
        tbl[4]  = '{1'b1, 1'b0, 32'hA0000002, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0000001, 1'b0, 32'h0,        2'd1, 2'd0};
        tbl[5]  = '{1'b1, 1'b0, 32'hA0000003, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA0000001, 1'b0, 32'h0,        2'd2, 2'd0};
        tbl[6]  = '{1'b1, 1'b1, 32'hB0000001, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0000001, 1'b0, 32'h0,        2'd2, 2'd0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hA0000001, 1'b1, 32'hB0000001, 2'd2, 2'd1};
        tbl[8]  = '{1'b1, 1'b0, 32'hC0000001, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0000002, 1'b1, 32'hB0000001, 2'd1, 2'd1};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'hC0000001, 1'b1, 32'hB0000001, 2'd1, 2'd1};
        tbl[10] = '{1'b1, 1'b1, 32'hD0000001, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC0000001, 1'b0, 32'h0,        2'd1, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hD0000001, 2'd0, 2'd1};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0, 2'd0};

        // Reset held: everything cleared.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out0_valid", {31'b0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("rst_out0_count", {30'b0, out0_count}, 32'd0);
        chk("rst_out1_count", {30'b0, out1_count}, 32'd0);
        chk("rst_out0_data", out0_data, 32'd0);
        chk("rst_out1_data", out1_data, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // Route, full/backpressure, simultaneous push+pop, cross-FIFO independence.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #1;
            $display("row %0d: v=%0b sel=%0b d=%08h rdy=%0b v0=%0b d0=%08h c0=%0d v1=%0b d1=%08h c1=%0d",
                     i, tbl[i].v, tbl[i].sel, tbl[i].d, in_ready, out0_valid, out0_data,
                     out0_count, out1_valid, out1_data, out1_count);
            chk($sformatf("row%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("row%0d_out0_valid", i), {31'b0, out0_valid}, {31'b0, tbl[i].e_v0});
            chk($sformatf("row%0d_out1_valid", i), {31'b0, out1_valid}, {31'b0, tbl[i].e_v1});
            chk($sformatf("row%0d_out0_count", i), {30'b0, out0_count}, {30'b0, tbl[i].e_c0});
            chk($sformatf("row%0d_out1_count", i), {30'b0, out1_count}, {30'b0, tbl[i].e_c1});
            if (tbl[i].e_v0) chk($sformatf("row%0d_out0_data", i), out0_data, tbl[i].e_d0);
            if (tbl[i].e_v1) chk($sformatf("row%0d_out1_data", i), out1_data, tbl[i].e_d1);
            tick();
        end

        // Wrap: 10 words to output 1 with sink ready toggling 1,0,1,0...
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            drive(sent < 10, 1'b1, 32'h5000_0000 + sent, 1'b0, (cyc % 2) == 0);
            #1;
            chk("wrap_count1_le_2", {31'b0, out1_count <= 2'd2}, 32'd1);
            if (out1_valid && out1_ready) begin
                $display("wrap pop %0d: data=%08h", got, out1_data);
                chk("wrap_data", out1_data, 32'h5000_0000 + got);
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        chk("wrap_words_received", got, 32'd10);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        tick();

        // Asynchronous reset mid-operation with count0=2, count1=1.
        drive(1'b1, 1'b0, 32'hE0000001, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 32'hE0000002, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 32'hE0000003, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_out0_count", {30'b0, out0_count}, 32'd2);
        chk("pre_rst_out1_count", {30'b0, out1_count}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: v0=%0b v1=%0b c0=%0d c1=%0d", out0_valid, out1_valid, out0_count, out1_count);
        chk("arst_out0_valid", {31'b0, out0_valid}, 32'd0);
        chk("arst_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("arst_out0_count", {30'b0, out0_count}, 32'd0);
        chk("arst_out1_count", {30'b0, out1_count}, 32'd0);
        chk("arst_out0_data", out0_data, 32'd0);
        chk("arst_out1_data", out1_data, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_out0_valid", {31'b0, out0_valid}, 32'd0);
            chk("post_rst_out1_valid", {31'b0, out1_valid}, 32'd0);
            chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
